// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Scan driver for an 8-digit multiplexed common-anode 7-segment
//               display. Shows a 32-bit word as 8 hex nibbles, digit 0 being
//               data_i[3:0] and digit 7 being data_i[31:28]. The word and the
//               decimal-point mask are captured into a shadow once per scan
//               frame, so a displayed word never tears across digits.
//
// Parameters  : TICK_DIV  clock cycles per digit slot (1..2^20)
//
// Ports       : clk_i    in   1   system clock
//               rst_i    in   1   asynchronous reset, active-low
//               data_i   in   32  word to display
//               dp_i     in   8   decimal point request per digit, 1 = lit
//               en_i     in   1   1 = display on, 0 = all anodes off
//               an_o     out  8   anode selects, active-low, one-hot-low
//               seg_o    out  7   segments {g,f,e,d,c,b,a}, active-low
//               dp_o     out  1   decimal point, active-low
//               frame_o  out  1   1-cycle pulse after each shadow load
//
// Build macro : SEG7_LZ_BLANK_EN - when defined, leading zeros are blanked
//               separately in the halves digits 3..0 and 7..4 (digits 0 and
//               4 are never blanked; the decimal point is unaffected).
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic        en_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    // A one-bit counter is kept for TICK_DIV=1 so the width is never zero;
    // it simply stays at 0 and every cycle is a tick.
    localparam int unsigned          c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0]   c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_PRE_W-1:0]   c_PRE_ONE = c_PRE_W'(1);

    logic [c_PRE_W-1:0] r_presc;
    logic [2:0]         r_dig;
    logic [31:0]        r_shadow;
    logic [7:0]         r_shadow_dp;
    logic               r_frame;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tick;
    logic               w_load;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic [6:0]         w_seg_next;

    assign w_tick = (r_presc == c_PRE_MAX);
    // The shadow is refreshed as the scan wraps from digit 7 back to digit 0,
    // so every frame starts on a freshly captured word.
    assign w_load = w_tick && (r_dig == 3'd7);
    assign w_nib  = r_shadow[{r_dig, 2'b00} +: 4];

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

`ifdef SEG7_LZ_BLANK_EN
    // A digit is blank when it and every digit above it within its own
    // 16-bit half are zero. The lowest digit of each half always shows.
    logic [7:0] w_blank;

    assign w_blank[0] = 1'b0;
    assign w_blank[1] = (r_shadow[15:4]  == 12'h000);
    assign w_blank[2] = (r_shadow[15:8]  == 8'h00);
    assign w_blank[3] = (r_shadow[15:12] == 4'h0);
    assign w_blank[4] = 1'b0;
    assign w_blank[5] = (r_shadow[31:20] == 12'h000);
    assign w_blank[6] = (r_shadow[31:24] == 8'h00);
    assign w_blank[7] = (r_shadow[31:28] == 4'h0);

    assign w_seg_next = w_blank[r_dig] ? 7'h7F : w_seg_dec;
`else
    assign w_seg_next = w_seg_dec;
`endif

    // Scan timing and shadow capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_presc     <= '0;
            r_dig       <= 3'd0;
            r_shadow    <= 32'h0000_0000;
            r_shadow_dp <= 8'h00;
            r_frame     <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + c_PRE_ONE);
            if (w_tick) begin
                r_dig <= r_dig + 3'd1;
            end
            if (w_load) begin
                r_shadow    <= data_i;
                r_shadow_dp <= dp_i;
            end
            r_frame <= w_load;
        end
    end

    // Anode, segment and dp are all registered on the same edge from the
    // same digit index, so the segments never briefly show a neighbour.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= en_i ? ~(8'h01 << r_dig) : 8'hFF;
            r_seg <= w_seg_next;
            r_dp  <= ~r_shadow_dp[r_dig];
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign frame_o = r_frame;

endmodule
`default_nettype wire
